// File: rtl/shift_req_ctrl_pkg.sv
// Shared definitions for the barrel-shifter request controller.
package shift_req_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // Shift kind carried in op[2:1]; op[0] selects immediate vs register form.
  typedef enum logic [1:0] {
    SH_LSL = 2'b00,
    SH_LSR = 2'b01,
    SH_ASR = 2'b10,
    SH_ROR = 2'b11
  } shift_kind_t;

  localparam logic PORT0 = 1'b0;
  localparam logic PORT1 = 1'b1;

  // LSL by zero performs no shift, so the shifter carry is meaningless there.
  function automatic logic carry_defined(input logic [2:0] op, input logic [7:0] num);
    return !((shift_kind_t'(op[2:1]) == SH_LSL) && (num == '0));
  endfunction

endpackage

// File: rtl/shift_req_ctrl_rr_arb2.sv
// Two-port round-robin arbiter with a registered priority pointer.
module rr_arb2 #(
  parameter logic RR_INIT = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] valid,
  input  logic       advance,
  output logic [1:0] grant,
  output logic       ptr
);
  import shift_req_ctrl_pkg::*;

  // One-hot grant: the pointer breaks ties, a lone request always wins.
  always_comb begin
    grant = valid;
    if (valid == 2'b11) begin
      grant = (ptr == PORT1) ? 2'b10 : 2'b01;
    end
  end

  // After a grant, priority moves to the port that was not served.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ptr <= RR_INIT;
    end else if (advance) begin
      ptr <= grant[0] ? PORT1 : PORT0;
    end
  end

endmodule

// File: rtl/shift_req_ctrl.sv
// Sequences shift requests from two requesters onto the shared barrel shifter
// and owns the architectural carry flag.
module shift_req_ctrl #(
  parameter logic RR_INIT = 1'b0,
  parameter logic CF_INIT = 1'b0
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req0_valid,
  input  logic        req1_valid,
  output logic        req0_ready,
  output logic        req1_ready,
  input  logic [31:0] req0_data,
  input  logic [31:0] req1_data,
  input  logic [7:0]  req0_num,
  input  logic [7:0]  req1_num,
  input  logic [2:0]  req0_op,
  input  logic [2:0]  req1_op,
  input  logic        req0_s,
  input  logic        req1_s,
  output logic        resp0_valid,
  output logic        resp1_valid,
  output logic [31:0] resp_data,
  output logic        resp_carry,
  output logic [31:0] sh_data,
  output logic [7:0]  sh_num,
  output logic [2:0]  sh_op,
  output logic        sh_cf,
  input  logic [31:0] sh_out,
  input  logic        sh_carry,
  input  logic        cf_load,
  input  logic        cf_load_val,
  output logic        cf,
  output logic        busy
);
  import shift_req_ctrl_pkg::*;

  state_t     state;
  state_t     state_next;
  logic [1:0] req_valid;
  logic [1:0] grant;
  logic       rr_ptr;
  logic       accept;
  logic       win_id;
  logic       port_id;
  logic       s_lat;

  assign req_valid = {req1_valid, req0_valid};
  // Winner id follows the pointer on contention, otherwise the lone valid port.
  assign win_id    = (req_valid == 2'b11) ? rr_ptr : req_valid[1];

  rr_arb2 #(.RR_INIT(RR_INIT)) u_arb (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid   (req_valid),
    .advance (accept),
    .grant   (grant),
    .ptr     (rr_ptr)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next state, handshake and response strobes.
  always_comb begin
    state_next  = state;
    accept      = 1'b0;
    req0_ready  = 1'b0;
    req1_ready  = 1'b0;
    resp0_valid = 1'b0;
    resp1_valid = 1'b0;
    busy        = 1'b1;
    unique case (state)
      ST_IDLE: begin
        busy       = 1'b0;
        req0_ready = grant[0];
        req1_ready = grant[1];
        accept     = |req_valid;
        if (accept) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        state_next = ST_DONE;
      end
      ST_DONE: begin
        resp0_valid = (port_id == PORT0);
        resp1_valid = (port_id == PORT1);
        state_next  = ST_IDLE;
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // Operand latch on acceptance, result capture in SHIFT.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sh_data    <= '0;
      sh_num     <= '0;
      sh_op      <= '0;
      port_id    <= PORT0;
      s_lat      <= 1'b0;
      resp_data  <= '0;
      resp_carry <= 1'b0;
    end else if (accept) begin
      sh_data <= (win_id == PORT1) ? req1_data : req0_data;
      sh_num  <= (win_id == PORT1) ? req1_num  : req0_num;
      sh_op   <= (win_id == PORT1) ? req1_op   : req0_op;
      s_lat   <= (win_id == PORT1) ? req1_s    : req0_s;
      port_id <= win_id;
    end else if (state == ST_SHIFT) begin
      resp_data  <= sh_out;
      resp_carry <= sh_carry;
    end
  end

  // Carry flag: external load wins over the capture-time update.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cf <= CF_INIT;
    end else if (cf_load) begin
      cf <= cf_load_val;
    end else if ((state == ST_SHIFT) && s_lat && carry_defined(sh_op, sh_num)) begin
      cf <= sh_carry;
    end
  end

  assign sh_cf = cf;

endmodule

// File: tb/tb_shift_req_ctrl.sv
// Directed bench for shift_req_ctrl with a behavioural barrel shifter attached.
module tb_shift_req_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [31:0] req0_data = '0, req1_data = '0;
  logic [7:0]  req0_num = '0, req1_num = '0;
  logic [2:0]  req0_op = '0, req1_op = '0;
  logic        req0_s = 1'b0, req1_s = 1'b0;
  logic        resp0_valid, resp1_valid;
  logic [31:0] resp_data;
  logic        resp_carry;
  logic [31:0] sh_data;
  logic [7:0]  sh_num;
  logic [2:0]  sh_op;
  logic        sh_cf;
  logic [31:0] sh_out;
  logic        sh_carry;
  logic        cf_load = 1'b0, cf_load_val = 1'b0;
  logic        cf, busy;
  logic [32:0] model;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  shift_req_ctrl #(.RR_INIT(1'b0), .CF_INIT(1'b0)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0_valid(req0_valid), .req1_valid(req1_valid),
    .req0_ready(req0_ready), .req1_ready(req1_ready),
    .req0_data(req0_data), .req1_data(req1_data),
    .req0_num(req0_num), .req1_num(req1_num),
    .req0_op(req0_op), .req1_op(req1_op),
    .req0_s(req0_s), .req1_s(req1_s),
    .resp0_valid(resp0_valid), .resp1_valid(resp1_valid),
    .resp_data(resp_data), .resp_carry(resp_carry),
    .sh_data(sh_data), .sh_num(sh_num), .sh_op(sh_op), .sh_cf(sh_cf),
    .sh_out(sh_out), .sh_carry(sh_carry),
    .cf_load(cf_load), .cf_load_val(cf_load_val),
    .cf(cf), .busy(busy)
  );

  // Stand-in for the external barrel shifter: returns {carry, result}.
  function automatic logic [32:0] shift_model(input logic [31:0] d, input logic [7:0] n,
                                              input logic [2:0] op, input logic c);
    int unsigned k;
    int unsigned r;
    logic [31:0] o;
    logic co;
    k = n;
    o = d;
    co = 1'b0;
    case (op[2:1])
      2'b00: begin
        if (k == 0) begin o = d; co = 1'b0; end
        else if (k < 32) begin o = d << k; co = d[32-k]; end
        else if (k == 32) begin o = '0; co = d[0]; end
        else begin o = '0; co = 1'b0; end
      end
      2'b01: begin
        if (k == 0) begin o = d; co = 1'b0; end
        else if (k < 32) begin o = d >> k; co = d[k-1]; end
        else if (k == 32) begin o = '0; co = d[31]; end
        else begin o = '0; co = 1'b0; end
      end
      2'b10: begin
        if (k == 0) begin o = d; co = 1'b0; end
        else if (k < 32) begin o = $unsigned($signed(d) >>> k); co = d[k-1]; end
        else begin o = {32{d[31]}}; co = d[31]; end
      end
      default: begin
        if (k == 0) begin o = {c, d[31:1]}; co = d[0]; end
        else begin
          r = k % 32;
          o = (r == 0) ? d : ((d >> r) | (d << (32 - r)));
          co = o[31];
        end
      end
    endcase
    return {co, o};
  endfunction

  always_comb begin
    model    = shift_model(sh_data, sh_num, sh_op, sh_cf);
    sh_out   = model[31:0];
    sh_carry = model[32];
  end

  task automatic drive(input int p, input logic [31:0] d, input logic [7:0] n,
                       input logic [2:0] op, input logic s);
    if (p == 0) begin
      req0_valid = 1'b1; req0_data = d; req0_num = n; req0_op = op; req0_s = s;
    end else begin
      req1_valid = 1'b1; req1_data = d; req1_num = n; req1_op = op; req1_s = s;
    end
  endtask

  task automatic clear_req();
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic load_cf(input logic v);
    @(negedge clk); cf_load = 1'b1; cf_load_val = v;
    @(negedge clk); cf_load = 1'b0;
  endtask

  task automatic apply_reset();
    @(negedge clk); rst_n = 1'b0; clear_req(); cf_load = 1'b0;
    @(negedge clk); @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_reset();
    apply_reset();
    #1;
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if ({req0_ready, req1_ready} !== 2'b00) begin failures++; $display("FAIL reset_ready got=%b exp=00", {req0_ready, req1_ready}); end
    checks++; if ({resp0_valid, resp1_valid} !== 2'b00) begin failures++; $display("FAIL reset_resp got=%b exp=00", {resp0_valid, resp1_valid}); end
    checks++; if (resp_data !== 32'h0) begin failures++; $display("FAIL reset_resp_data got=%h exp=0", resp_data); end
    checks++; if ({sh_data, sh_num, sh_op} !== 43'h0) begin failures++; $display("FAIL reset_sh got=%h exp=0", {sh_data, sh_num, sh_op}); end
    checks++; if (cf !== 1'b0) begin failures++; $display("FAIL reset_cf got=%b exp=0", cf); end
  endtask

  task automatic test_single_lsr();
    @(negedge clk); drive(0, 32'h80000000, 8'd4, 3'b011, 1'b0); #1;
    checks++; if ({req1_ready, req0_ready} !== 2'b01) begin failures++; $display("FAIL lsr_ready got=%b exp=01", {req1_ready, req0_ready}); end
    @(negedge clk); #1;
    checks++; if (req0_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL lsr_shift_state got=%b%b exp=01", req0_ready, busy); end
    checks++; if (sh_data !== 32'h80000000 || sh_num !== 8'd4 || sh_op !== 3'b011) begin failures++; $display("FAIL lsr_operands got=%h/%0d/%b exp=80000000/4/011", sh_data, sh_num, sh_op); end
    clear_req();
    checks++; if (resp0_valid !== 1'b0) begin failures++; $display("FAIL lsr_early_resp got=%b exp=0", resp0_valid); end
    @(negedge clk); #1;
    checks++; if ({resp1_valid, resp0_valid} !== 2'b01) begin failures++; $display("FAIL lsr_resp got=%b exp=01", {resp1_valid, resp0_valid}); end
    checks++; if (resp_data !== 32'h08000000) begin failures++; $display("FAIL lsr_data got=%h exp=08000000", resp_data); end
    checks++; if (cf !== 1'b0) begin failures++; $display("FAIL lsr_cf got=%b exp=0", cf); end
    @(negedge clk); #1;
    checks++; if (resp0_valid !== 1'b0 || busy !== 1'b0) begin failures++; $display("FAIL lsr_resp_end got=%b%b exp=00", resp0_valid, busy); end
  endtask

  task automatic test_asr();
    load_cf(1'b1); #1;
    checks++; if (cf !== 1'b1) begin failures++; $display("FAIL cf_load_set got=%b exp=1", cf); end
    drive(1, 32'h80000000, 8'd4, 3'b101, 1'b1);
    @(negedge clk); clear_req();
    @(negedge clk); #1;
    checks++; if ({resp1_valid, resp0_valid} !== 2'b10) begin failures++; $display("FAIL asr_resp got=%b exp=10", {resp1_valid, resp0_valid}); end
    checks++; if (resp_data !== 32'hF8000000 || resp_carry !== 1'b0) begin failures++; $display("FAIL asr_data got=%h/%b exp=f8000000/0", resp_data, resp_carry); end
    checks++; if (cf !== 1'b0) begin failures++; $display("FAIL asr_cf got=%b exp=0", cf); end
  endtask

  task automatic test_ror_rrx();
    @(negedge clk); drive(0, 32'h00000001, 8'd1, 3'b111, 1'b1);
    @(negedge clk); clear_req();
    @(negedge clk); #1;
    checks++; if (resp_data !== 32'h80000000 || resp_carry !== 1'b1) begin failures++; $display("FAIL ror_data got=%h/%b exp=80000000/1", resp_data, resp_carry); end
    checks++; if (cf !== 1'b1) begin failures++; $display("FAIL ror_cf got=%b exp=1", cf); end
    // RRX must shift in the carry as it stood before this capture (1).
    @(negedge clk); drive(0, 32'h00000002, 8'd0, 3'b110, 1'b1);
    @(negedge clk); clear_req();
    @(negedge clk); #1;
    checks++; if (resp_data !== 32'h80000001 || resp_carry !== 1'b0) begin failures++; $display("FAIL rrx_data got=%h/%b exp=80000001/0", resp_data, resp_carry); end
    checks++; if (cf !== 1'b0) begin failures++; $display("FAIL rrx_cf got=%b exp=0", cf); end
  endtask

  task automatic test_contention();
    bit exp_port, exp_r0, exp_r1, exp_v0, exp_v1;
    apply_reset();
    drive(0, 32'h00000011, 8'd0, 3'b001, 1'b0);
    drive(1, 32'h00000022, 8'd0, 3'b001, 1'b0);
    for (int c = 0; c < 12; c++) begin
      #1;
      exp_port = ((c / 3) % 2) == 1;
      exp_r0 = (c % 3 == 0) && !exp_port;
      exp_r1 = (c % 3 == 0) && exp_port;
      exp_v0 = (c % 3 == 2) && !exp_port;
      exp_v1 = (c % 3 == 2) && exp_port;
      checks++; if ({req1_ready, req0_ready} !== {exp_r1, exp_r0}) begin failures++; $display("FAIL rr_ready c=%0d got=%b exp=%b", c, {req1_ready, req0_ready}, {exp_r1, exp_r0}); end
      checks++; if ({resp1_valid, resp0_valid} !== {exp_v1, exp_v0}) begin failures++; $display("FAIL rr_resp c=%0d got=%b exp=%b", c, {resp1_valid, resp0_valid}, {exp_v1, exp_v0}); end
      if (c % 3 == 2) begin
        checks++; if (resp_data !== (exp_port ? 32'h22 : 32'h11)) begin failures++; $display("FAIL rr_data c=%0d got=%h exp=%h", c, resp_data, exp_port ? 32'h22 : 32'h11); end
      end
      @(negedge clk);
    end
    clear_req();
  endtask

  task automatic test_lsl0_cf_priority();
    load_cf(1'b1);
    drive(0, 32'h12345678, 8'd0, 3'b001, 1'b1);
    @(negedge clk); clear_req();
    @(negedge clk); #1;
    checks++; if (resp_data !== 32'h12345678) begin failures++; $display("FAIL lsl0_data got=%h exp=12345678", resp_data); end
    checks++; if (cf !== 1'b1) begin failures++; $display("FAIL lsl0_cf got=%b exp=1", cf); end
    // Capture with carry 1 and s=1 while an external load of 0 lands in the same cycle.
    @(negedge clk); drive(0, 32'h00000001, 8'd1, 3'b111, 1'b1);
    @(negedge clk); clear_req(); cf_load = 1'b1; cf_load_val = 1'b0;
    @(negedge clk); cf_load = 1'b0; #1;
    checks++; if (resp_carry !== 1'b1) begin failures++; $display("FAIL load_prio_carry got=%b exp=1", resp_carry); end
    checks++; if (cf !== 1'b0) begin failures++; $display("FAIL load_prio_cf got=%b exp=0", cf); end
  endtask

  task automatic test_large_amount();
    load_cf(1'b1);
    drive(1, 32'hFFFFFFFF, 8'd40, 3'b011, 1'b1);
    @(negedge clk); clear_req(); #1;
    checks++; if (sh_num !== 8'd40) begin failures++; $display("FAIL big_num got=%0d exp=40", sh_num); end
    @(negedge clk); #1;
    checks++; if (resp_data !== 32'h0 || cf !== 1'b0 || resp1_valid !== 1'b1) begin failures++; $display("FAIL big_result got=%h/%b/%b exp=0/0/1", resp_data, cf, resp1_valid); end
  endtask

  task automatic test_mid_reset();
    bit saw_resp;
    load_cf(1'b1);
    drive(0, 32'h00000001, 8'd1, 3'b111, 1'b1);
    @(negedge clk); clear_req(); rst_n = 1'b0; #1;
    checks++; if (busy !== 1'b0 || resp_data !== 32'h0 || sh_data !== 32'h0) begin failures++; $display("FAIL midrst_outputs got=%b/%h/%h exp=0/0/0", busy, resp_data, sh_data); end
    checks++; if (cf !== 1'b0) begin failures++; $display("FAIL midrst_cf got=%b exp=0", cf); end
    saw_resp = 1'b0;
    @(negedge clk); rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1; if (resp0_valid || resp1_valid) saw_resp = 1'b1;
      @(negedge clk);
    end
    checks++; if (saw_resp !== 1'b0) begin failures++; $display("FAIL midrst_dropped got=%b exp=0", saw_resp); end
    drive(0, 32'h00000003, 8'd2, 3'b000, 1'b0);
    @(negedge clk); clear_req();
    @(negedge clk); #1;
    checks++; if (resp0_valid !== 1'b1 || resp_data !== 32'h0000000C) begin failures++; $display("FAIL midrst_after got=%b/%h exp=1/0000000c", resp0_valid, resp_data); end
  endtask

  initial begin
    test_reset();
    test_single_lsr();
    test_asr();
    test_ror_rrx();
    test_contention();
    test_lsl0_cf_priority();
    test_large_amount();
    test_mid_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/shift_req_ctrl.md
Name: shift_req_ctrl

Overview:
Sequencing and arbitration controller for the shared 32-bit barrel shifter. It accepts shift requests from two requesters (port 0: operand-2 datapath, port 1: debug/console path) over valid/ready and grants one at a time, round-robin. It registers the operands, drives the combinational shifter, captures result and carry, and returns a one-cycle response. It also owns the architectural carry flag (CF) that feeds the shifter's RRX input.

Parameters:
RR_INIT, 0, port holding priority after reset (0 or 1)
CF_INIT, 0, CF value after reset

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
req0_valid / req1_valid  in  1  request pending on port 0 / port 1
req0_ready / req1_ready  out  1  request accepted this cycle
req0_data / req1_data  in  32  value to shift
req0_num / req1_num  in  8  shift amount
req0_op / req1_op  in  3  [2:1] 00 LSL, 01 LSR, 10 ASR, 11 ROR/RRX; [0] 1 = immediate form, 0 = register form
req0_s / req1_s  in  1  update CF from shifter carry
resp0_valid / resp1_valid  out  1  one-cycle response pulse to the granted port
resp_data  out  32  captured shift result
resp_carry  out  1  captured shifter carry
sh_data  out  32  to shifter Shift_Data
sh_num  out  8  to shifter Shift_Num
sh_op  out  3  to shifter Shift_Op
sh_cf  out  1  to shifter CF (equals cf)
sh_out  in  32  from shifter W_Shift_Out
sh_carry  in  1  from shifter W_Shift_Carry_Out
cf_load  in  1  external CF write strobe
cf_load_val  in  1  value for external CF write
cf  out  1  current carry flag
busy  out  1  high in any state other than IDLE

Behaviour:
- Reset (async, rst_n=0): state=IDLE; ready, resp_valid=0; resp_data=0; resp_carry=0; sh_data/num/op=0; cf=CF_INIT; priority pointer=RR_INIT. A transaction in flight is dropped with no response.
- FSM states: IDLE -> SHIFT -> DONE -> IDLE.
- IDLE: reqN_ready is combinational. It is high only for the winner among the valid ports. If both are valid, the winner is the port named by the priority pointer. Handshake occurs on valid&&ready. On acceptance: operands latch into sh_data/sh_num/sh_op; port id and s latch; state goes to SHIFT; pointer goes to the other port.
- Ready is 0 in SHIFT and DONE. Requesters hold valid and operands stable until ready.
- SHIFT: sh_* are stable from registers. At the clock edge, sh_out goes to resp_data and sh_carry to resp_carry. Then state=DONE.
- DONE: respN_valid=1 for exactly one cycle on the latched port, then IDLE. resp_data/resp_carry hold until the next capture.
- Latency: acceptance at edge N, resp_valid high in cycle N+2. Max throughput is 1 request per 3 cycles. No back-to-back acceptance.
- CF update: at the SHIFT capture edge, cf<=sh_carry if s=1, excluding sh_op[2:1]=00 with sh_num=0 (no shift, so carry is undefined and cf is kept). cf_load has priority over capture in the same cycle.
- sh_cf=cf at all times, so RRX (op 110, num 0) uses CF as it stood before the capture.
- Amounts over 32 pass to the shifter unmodified. The controller does no clamping.
- Fairness: a continuously valid port is served at most one grant after the other.

Decomposition:
- Shared package/header: op encodings (LSL, LSR, ASR, ROR), FSM state encodings, port-id constants.
- One sub-module: rr_arb2. It takes 2 valids, the pointer and an advance strobe, and produces a one-hot grant plus the registered pointer.
- The barrel shifter stays external and is instantiated alongside this block by the parent.

Test Plan:
- Single request: port0 data=0x80000000, num=4, op=011 (LSR), s=0 -> req0_ready same cycle; resp0_valid two cycles later; resp_data=0x08000000; cf unchanged.
- ASR: port1 data=0x80000000, num=4, op=101, s=1 -> resp1_valid; resp_data=0xF8000000; resp_carry=0; cf=0.
- ROR with flag: data=0x00000001, num=1, op=111, s=1, cf=0 -> resp_data=0x80000000, resp_carry=1, cf=1.
- Contention: both valid after reset (RR_INIT=0), both held -> grants 0,1,0,1. Grants are 3 cycles apart; no responses overlap.
- LSL by 0 with s=1, cf preset to 1 via cf_load -> resp_data=data; cf stays 1. Then cf_load=1, cf_load_val=0 in the same cycle as a capture with s=1 and sh_carry=1 -> cf=0.
- Mid-operation reset: assert rst_n=0 in SHIFT -> all outputs at reset values, no resp_valid. After release, a new request completes normally.
